// File: rtl/apb_master_fsm.sv
// APB requester: turns one accepted valid/ready command into a single APB SETUP+ACCESS
// transfer and returns the completion (read data, slave error or timeout) on a response port.
module apb_master_fsm #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  preset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // The counter holds (ACCESS cycles elapsed - 1), so it only needs to reach TIMEOUT_CYCLES-1.
  localparam int CW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TLAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] LP_TLAST = CW'(TLAST_INT);

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [CW-1:0]         r_tcnt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  r_rsp_timeout;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_tmo;

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_done   = (r_state == S_ACCESS) && pready;
  // pready on the final allowed ACCESS cycle takes priority over the timeout.
  assign w_tmo    = (TIMEOUT_CYCLES != 0) && (r_state == S_ACCESS) && !pready
                    && (r_tcnt == LP_TLAST);

  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    psel         = 1'b0;
    penable      = 1'b0;
    rsp_valid    = 1'b0;
    pwdata       = '0;
    rsp_rdata    = '0;
    rsp_err      = 1'b0;
    rsp_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next_state = S_SETUP;
      end
      S_SETUP: begin
        psel         = 1'b1;
        pwdata       = r_write ? r_wdata : '0;
        w_next_state = S_ACCESS;
      end
      S_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        pwdata  = r_write ? r_wdata : '0;
        if (w_done || w_tmo) w_next_state = S_RESP;
      end
      S_RESP: begin
        rsp_valid   = 1'b1;
        rsp_rdata   = r_rsp_rdata;
        rsp_err     = r_rsp_err;
        rsp_timeout = r_rsp_timeout;
        if (rsp_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign paddr  = r_addr;
  assign pwrite = r_write;

  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      r_addr        <= '0;
      r_write       <= 1'b0;
      r_wdata       <= '0;
      r_tcnt        <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= req_addr;
        r_write <= req_write;
        r_wdata <= req_wdata;
      end
      if (r_state == S_SETUP) begin
        r_tcnt <= '0;
      end else if (r_state == S_ACCESS) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_done) begin
        r_rsp_err     <= pslverr;
        r_rsp_timeout <= 1'b0;
        r_rsp_rdata   <= (!r_write && !pslverr) ? prdata : '0;
      end else if (w_tmo) begin
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= 1'b1;
        r_rsp_rdata   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_fsm.sv
// Directed bench for apb_master_fsm: a transaction-level model is compared against the DUT
// every cycle, and literal expectations pin the key cycles of each scenario.
module tb_apb_master_fsm;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk;
  logic          preset_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  int assertCount = 0;
  int failCount   = 0;

  apb_master_fsm #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .preset_n   (preset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .paddr      (paddr),
    .pwrite     (pwrite),
    .psel       (psel),
    .penable    (penable),
    .pwdata     (pwdata),
    .pready     (pready),
    .prdata     (prdata),
    .pslverr    (pslverr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a transfer in flight counts ACCESS cycles; a completed transfer sits in a
  // one-deep response queue until consumed.
  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } rsp_t;

  bit            mBusy;
  int            mAcc;
  rsp_t          mRsp[$];
  logic [AW-1:0] mAddr;
  logic          mWrite;
  logic [DW-1:0] mWdata;

  always @(posedge clk or negedge preset_n) begin
    rsp_t r;
    if (!preset_n) begin
      mBusy  = 1'b0;
      mAcc   = 0;
      mRsp.delete();
      mAddr  = '0;
      mWrite = 1'b0;
      mWdata = '0;
    end else if (mRsp.size() != 0) begin
      if (rsp_ready) mRsp.delete();
    end else if (!mBusy) begin
      if (req_valid) begin
        mBusy  = 1'b1;
        mAcc   = 0;
        mAddr  = req_addr;
        mWrite = req_write;
        mWdata = req_wdata;
      end
    end else if (mAcc == 0) begin
      mAcc = 1;
    end else if (pready) begin
      r.err   = pslverr;
      r.tmo   = 1'b0;
      r.rdata = (!mWrite && !pslverr) ? prdata : '0;
      mRsp.push_back(r);
      mBusy = 1'b0;
    end else if (TMO != 0 && mAcc == TMO) begin
      r.err   = 1'b1;
      r.tmo   = 1'b1;
      r.rdata = '0;
      mRsp.push_back(r);
      mBusy = 1'b0;
    end else begin
      mAcc = mAcc + 1;
    end
  end

  always @(negedge clk) begin
    bit idle;
    bit haveRsp;
    if (preset_n) begin
      haveRsp = (mRsp.size() != 0);
      idle    = !mBusy && !haveRsp;
      checkOutput("req_ready", 64'(req_ready), 64'(idle));
      checkOutput("psel", 64'(psel), 64'(mBusy));
      checkOutput("penable", 64'(penable), 64'(mBusy && mAcc > 0));
      checkOutput("paddr", 64'(paddr), 64'(mAddr));
      checkOutput("pwrite", 64'(pwrite), 64'(mWrite));
      checkOutput("pwdata", 64'(pwdata), 64'((mBusy && mWrite) ? mWdata : '0));
      checkOutput("rsp_valid", 64'(rsp_valid), 64'(haveRsp));
      checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(haveRsp ? mRsp[0].rdata : '0));
      checkOutput("rsp_err", 64'(rsp_err), 64'(haveRsp ? mRsp[0].err : 1'b0));
      checkOutput("rsp_timeout", 64'(rsp_timeout), 64'(haveRsp ? mRsp[0].tmo : 1'b0));
    end
  end

  // Waits for the next rising edge, then drives every input for the cycle just begun.
  task automatic applyStimulus(input logic v, input logic [AW-1:0] a, input logic w,
                               input logic [DW-1:0] wd, input logic rdy,
                               input logic [DW-1:0] prd, input logic err, input logic rr);
    @(posedge clk);
    #1;
    req_valid = v;
    req_addr  = a;
    req_write = w;
    req_wdata = wd;
    pready    = rdy;
    prdata    = prd;
    pslverr   = err;
    rsp_ready = rr;
  endtask

  typedef struct {
    logic [DW-1:0] setupPwdata;
    logic [AW-1:0] setupPaddr;
    logic          setupPsel;
    logic          setupPen;
    logic          respPsel;
    logic          respValid;
    logic          respReqReady;
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } cap_t;

  // Runs one transfer from an IDLE cycle through the RESP handshake, returning on the
  // handshake cycle so a following call presents its command in the very next (IDLE) cycle.
  task automatic runXfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                         input int waits, input logic [DW-1:0] prd, input logic err,
                         input int bp, output cap_t c);
    applyStimulus(1'b1, addr, wr, wd, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, addr, wr, wd, 1'b0, '0, 1'b0, 1'b0);
    c.setupPwdata = pwdata;
    c.setupPaddr  = paddr;
    c.setupPsel   = psel;
    c.setupPen    = penable;
    for (int i = 0; i < waits; i++) applyStimulus(1'b0, addr, wr, wd, 1'b0, '0, 1'b0, 1'b0);
    if (waits < TMO) applyStimulus(1'b0, addr, wr, wd, 1'b1, prd, err, 1'b0);
    for (int k = 0; k <= bp; k++) begin
      applyStimulus(bp > 0, ~addr, 1'b1, 32'h0BAD_0BAD, 1'b0, '0, 1'b0, k == bp);
      if (k == 0) begin
        c.respPsel     = psel;
        c.respValid    = rsp_valid;
        c.respReqReady = req_ready;
        c.rdata        = rsp_rdata;
        c.err          = rsp_err;
        c.tmo          = rsp_timeout;
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cap_t c;
    preset_n  = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    pready    = 1'b0;
    prdata    = '0;
    pslverr   = 1'b0;
    rsp_ready = 1'b0;
    #2;
    checkOutput("reset req_ready", 64'(req_ready), 64'd1);
    checkOutput("reset psel", 64'(psel), 64'd0);
    checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset paddr", 64'(paddr), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 preset_n = 1'b1;

    $display("[TB] write, zero wait states");
    runXfer(16'h0010, 1'b1, 32'hDEAD_BEEF, 0, '0, 1'b0, 0, c);
    checkOutput("wr setup psel", 64'(c.setupPsel), 64'd1);
    checkOutput("wr setup penable", 64'(c.setupPen), 64'd0);
    checkOutput("wr setup pwdata", 64'(c.setupPwdata), 64'hDEAD_BEEF);
    checkOutput("wr setup paddr", 64'(c.setupPaddr), 64'h0010);
    checkOutput("wr rsp_valid", 64'(c.respValid), 64'd1);
    checkOutput("wr rsp_err", 64'(c.err), 64'd0);
    checkOutput("wr rsp_rdata", 64'(c.rdata), 64'd0);

    $display("[TB] read, three wait states");
    runXfer(16'h00A4, 1'b0, 32'h1111_2222, 3, 32'hCAFE_F00D, 1'b0, 0, c);
    checkOutput("rd setup pwdata", 64'(c.setupPwdata), 64'd0);
    checkOutput("rd rsp_rdata", 64'(c.rdata), 64'hCAFE_F00D);
    checkOutput("rd rsp_err", 64'(c.err), 64'd0);
    checkOutput("rd rsp_timeout", 64'(c.tmo), 64'd0);

    $display("[TB] read with slave error");
    runXfer(16'h0044, 1'b0, '0, 1, 32'h1234_5678, 1'b1, 0, c);
    checkOutput("slverr rsp_err", 64'(c.err), 64'd1);
    checkOutput("slverr rsp_timeout", 64'(c.tmo), 64'd0);
    checkOutput("slverr rsp_rdata", 64'(c.rdata), 64'd0);

    $display("[TB] timeout with pready held low");
    runXfer(16'h0088, 1'b0, '0, TMO, '0, 1'b0, 0, c);
    checkOutput("tmo rsp_err", 64'(c.err), 64'd1);
    checkOutput("tmo rsp_timeout", 64'(c.tmo), 64'd1);
    checkOutput("tmo rsp_rdata", 64'(c.rdata), 64'd0);
    checkOutput("tmo psel", 64'(c.respPsel), 64'd0);

    $display("[TB] pready on final allowed access cycle");
    runXfer(16'h00C0, 1'b1, 32'hA5A5_5A5A, TMO - 1, 32'hFFFF_FFFF, 1'b0, 0, c);
    checkOutput("late rsp_timeout", 64'(c.tmo), 64'd0);
    checkOutput("late rsp_err", 64'(c.err), 64'd0);
    checkOutput("late rsp_rdata", 64'(c.rdata), 64'd0);

    $display("[TB] response backpressure, then back-to-back command");
    runXfer(16'h0200, 1'b0, '0, 0, 32'h55AA_55AA, 1'b0, 5, c);
    checkOutput("bp req_ready", 64'(c.respReqReady), 64'd0);
    checkOutput("bp rsp_rdata", 64'(c.rdata), 64'h55AA_55AA);
    runXfer(16'h0300, 1'b1, 32'h0000_BEEF, 0, '0, 1'b0, 0, c);
    checkOutput("b2b setup paddr", 64'(c.setupPaddr), 64'h0300);
    checkOutput("b2b setup pwdata", 64'(c.setupPwdata), 64'h0000_BEEF);

    $display("[TB] reset during access");
    applyStimulus(1'b1, 16'h0400, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0400, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0400, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("pre-reset penable", 64'(penable), 64'd1);
    #2 preset_n = 1'b0;
    #1;
    checkOutput("async psel", 64'(psel), 64'd0);
    checkOutput("async penable", 64'(penable), 64'd0);
    checkOutput("async rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("async req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    #1 preset_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 32'hDEAD_DEAD, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 32'hDEAD_DEAD, 1'b0, 1'b1);
    checkOutput("post-reset req_ready", 64'(req_ready), 64'd1);
    checkOutput("post-reset rsp_valid", 64'(rsp_valid), 64'd0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
